// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the alu_md execute-stage ALU and its iterative
// multiply/divide engine: the default operand width, the 5-bit operation
// codes and the controller state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Base integer group (op[4] = 0)
    localparam logic [4:0] OP_AND    = 5'b00000;
    localparam logic [4:0] OP_OR     = 5'b00001;
    localparam logic [4:0] OP_ADD    = 5'b00010;
    localparam logic [4:0] OP_XOR    = 5'b00011;
    localparam logic [4:0] OP_SLL    = 5'b00100;
    localparam logic [4:0] OP_SRL    = 5'b00101;
    localparam logic [4:0] OP_SUB    = 5'b00110;
    localparam logic [4:0] OP_SLT    = 5'b00111;
    localparam logic [4:0] OP_SRA    = 5'b01000;
    localparam logic [4:0] OP_SLTU   = 5'b01001;

    // Multiply/divide group (op[4] = 1)
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_muldiv.sv
// -----------------------------------------------------------------------------
// seq_muldiv
// Iterative multiply/divide engine, one bit per cycle on a single shared
// 2*XLEN shift register.
//   Multiply: radix-2 shift-add on operand magnitudes.
//   Divide  : restoring division on operand magnitudes; the register holds
//             {remainder, quotient/dividend}.
// Signs are stripped on start and re-applied on the final iteration, where
// the high/low half (multiply) or quotient/remainder (divide) is selected.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         load operands and begin (one-cycle pulse)
//   kill          abandon the operation in flight
//   op[2:0]       low bits of the M-group op code (op[2]=1 selects divide)
//   a, b          operands (sampled on start)
//   done          high during the final iteration cycle
//   result        final result, valid while done is high
// -----------------------------------------------------------------------------
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    logic              active_reg;
    logic [CW-1:0]     cnt_reg;
    logic              is_div_reg;
    logic [1:0]        sel_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   opnd_reg;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_diff;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, quo_f, rem_f;

    // Operand signedness: MUL low half is sign-agnostic, so it runs unsigned.
    always_comb begin
        a_signed = op[2] ? ~op[0] : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
        b_signed = op[2] ? ~op[0] : (op[1:0] == 2'b01);
        a_neg    = a_signed & a[XLEN-1];
        b_neg    = b_signed & b[XLEN-1];
        // -2^(XLEN-1) maps to 2^(XLEN-1), which is correct as an unsigned magnitude.
        mag_a    = a_neg ? (~a + 1'b1) : a;
        mag_b    = b_neg ? (~b + 1'b1) : b;
    end

    // One iteration of the shared datapath.
    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        rem_shift = acc_reg[2*XLEN-1:XLEN-1];
        rem_ge    = (rem_shift >= {1'b0, opnd_reg});
        // When rem_ge holds the true difference is below the divisor, so the
        // low XLEN bits of the subtraction are exact.
        rem_diff  = rem_shift[XLEN-1:0] - opnd_reg;
        if (is_div_reg) begin
            acc_step = rem_ge ? {rem_diff, acc_reg[XLEN-2:0], 1'b1}
                              : {acc_reg[2*XLEN-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_reg[XLEN-1:1]};
        end
    end

    // Sign fix-up and selection applied to the final iteration's value.
    always_comb begin
        prod  = neg_q_reg ? (~acc_step + 1'b1) : acc_step;
        quo   = acc_step[XLEN-1:0];
        rem   = acc_step[2*XLEN-1:XLEN];
        quo_f = neg_q_reg ? (~quo + 1'b1) : quo;
        rem_f = neg_r_reg ? (~rem + 1'b1) : rem;
        if (is_div_reg) begin
            result = sel_reg[1] ? rem_f : quo_f;
        end else begin
            result = (sel_reg == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        done = active_reg && (cnt_reg == CW'(XLEN-1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg <= 1'b0;
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            sel_reg    <= 2'b00;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
        end else if (kill) begin
            active_reg <= 1'b0;
            cnt_reg    <= '0;
        end else if (start) begin
            active_reg <= 1'b1;
            cnt_reg    <= '0;
            is_div_reg <= op[2];
            sel_reg    <= op[1:0];
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            acc_reg    <= {{XLEN{1'b0}}, mag_a};
            opnd_reg   <= mag_b;
        end else if (active_reg) begin
            acc_reg <= acc_step;
            if (done) begin
                active_reg <= 1'b0;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_md.sv
// -----------------------------------------------------------------------------
// alu_md
// Execute-stage ALU: ten single-cycle base operations plus the RV M group
// behind a valid/ready handshake. Multiply and divide run on seq_muldiv;
// divide-by-zero and signed overflow are resolved at acceptance.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (transfer on both high)
//   op[4:0], a, b         operation and operands
//   kill                  abort in-flight op, drop result, refuse new op
//   out_valid / out_ready result handshake, one result held at most
//   res                   registered result
//   zero                  res == 0
//   busy                  iterative op in progress
// -----------------------------------------------------------------------------
module alu_md
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic            zero,
    output logic            busy
);

    state_t          state_reg, state_next;
    logic            out_valid_reg;
    logic [XLEN-1:0] res_reg;

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res, special_res, imm_res;
    logic            is_mul, is_div, div_rem, b_zero, div_ovf, div_special, iterative;
    logic            accept, eng_start, eng_done;
    logic [XLEN-1:0] eng_result;

    // Base-op mux. Every code outside the base group, including M codes,
    // falls to 0; M results are selected elsewhere.
    always_comb begin
        shamt    = b[SHW-1:0];
        base_res = '0;
        case (op)
            OP_AND:  base_res = a & b;
            OP_OR:   base_res = a | b;
            OP_ADD:  base_res = a + b;
            OP_XOR:  base_res = a ^ b;
            OP_SLL:  base_res = a << shamt;
            OP_SRL:  base_res = a >> shamt;
            OP_SUB:  base_res = a - b;
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SRA:  base_res = $signed(a) >>> shamt;
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (a < b)};
            default: base_res = '0;
        endcase
    end

    // Divide special cases resolve immediately and never start the engine.
    always_comb begin
        is_mul      = (op[4:2] == 3'b100);
        is_div      = (op[4:2] == 3'b101);
        div_rem     = op[1];
        b_zero      = (b == '0);
        div_ovf     = ~op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        div_special = is_div && (b_zero || div_ovf);
        if (b_zero) begin
            special_res = div_rem ? a : '1;
        end else begin
            special_res = div_rem ? '0 : a;
        end
        imm_res   = div_special ? special_res : base_res;
        iterative = is_mul || (is_div && !div_special);
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state (kill overrides everything)
    always_comb begin
        state_next = state_reg;
        if (kill) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept && is_mul) begin
                        state_next = ST_MUL;
                    end else if (accept && is_div && !div_special) begin
                        state_next = ST_DIV;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (eng_done) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
        busy      = (state_reg != ST_IDLE);
        accept    = in_valid && in_ready && !kill;
        eng_start = accept && iterative;
    end

    // Result register: a new result always replaces a consumed one in the
    // same cycle, giving one-op-per-cycle throughput for base ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else if (kill) begin
            out_valid_reg <= 1'b0;
        end else if (accept && !iterative) begin
            res_reg       <= imm_res;
            out_valid_reg <= 1'b1;
        end else if (eng_done) begin
            res_reg       <= eng_result;
            out_valid_reg <= 1'b1;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    seq_muldiv #(
        .XLEN (XLEN)
    ) u_seq_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (eng_start),
        .kill   (kill),
        .op     (op[2:0]),
        .a      (a),
        .b      (b),
        .done   (eng_done),
        .result (eng_result)
    );

    assign out_valid = out_valid_reg;
    assign res       = res_reg;
    assign zero      = (res_reg == '0);

endmodule

// File: tb/tb_alu_md.sv
// -----------------------------------------------------------------------------
// tb_alu_md
// Self-checking bench for alu_md (XLEN = 32): a vector table, directed
// handshake/kill/reset sequences and random ops against a behavioural model.
// Latency counts the accepting edge as edge 1.
// -----------------------------------------------------------------------------
module tb_alu_md;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a, b;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] res;
    logic            zero;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_md #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] r, input int l, input string n);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.res = r; v.lat = l; v.name = n;
        vecs.push_back(v);
    endfunction

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        int          sh;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        sh = int'(y[4:0]);
        case (o)
            5'b00000: return x & y;
            5'b00001: return x | y;
            5'b00010: return x + y;
            5'b00011: return x ^ y;
            5'b00100: return x << sh;
            5'b00101: return x >> sh;
            5'b00110: return x - y;
            5'b00111: return {31'b0, sx < sy};
            5'b01000: begin p = sx >>> sh; return p[31:0]; end
            5'b01001: return {31'b0, ux < uy};
            5'b10000: begin p = sx * sy; return p[31:0]; end
            5'b10001: begin p = sx * sy; return p[63:32]; end
            5'b10010: begin p = sx * uy; return p[63:32]; end
            5'b10011: begin p = ux * uy; return p[63:32]; end
            5'b10100: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                p = sx / sy; return p[31:0];
            end
            5'b10101: begin
                if (y == 0) return 32'hFFFF_FFFF;
                p = ux / uy; return p[31:0];
            end
            5'b10110: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                p = sx % sy; return p[31:0];
            end
            5'b10111: begin
                if (y == 0) return x;
                p = ux % uy; return p[31:0];
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[4:2] == 3'b100) return XLEN + 1;
        if (o[4:2] == 3'b101) begin
            if (y == 0) return 1;
            if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
            return XLEN + 1;
        end
        return 1;
    endfunction

    // Issue one op, wait for its result and check value, latency, busy span and zero.
    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_res, input int exp_lat, input string name);
        int lat;
        int busy_cnt;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check({name, " in_ready"}, 64'(in_ready), 64'(1));
            return;
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " out_valid"}, 64'(out_valid), 64'(1));
        check({name, " res"}, 64'(res), 64'(exp_res));
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy cycles"}, 64'(busy_cnt), 64'((exp_lat > 1) ? XLEN : 0));
        check({name, " zero"}, 64'(zero), 64'(exp_res == 32'h0));
        $display("txn %-10s op=%05b a=0x%08h b=0x%08h res=0x%08h lat=%0d", name, o, x, y, res, lat);
    endtask

    initial begin
        logic [4:0]  r_op;
        logic [31:0] r_a, r_b, r_exp;
        int          ov_seen;

        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
        kill = 1'b0; out_ready = 1'b1;

        add_vec(5'b00000, 32'hFFFF_FFF0, 32'h24, 32'h0000_0020, 1, "AND");
        add_vec(5'b00001, 32'hFFFF_FFF0, 32'h24, 32'hFFFF_FFF4, 1, "OR");
        add_vec(5'b00010, 32'hFFFF_FFF0, 32'h24, 32'h0000_0014, 1, "ADD");
        add_vec(5'b00011, 32'hFFFF_FFF0, 32'h24, 32'hFFFF_FFD4, 1, "XOR");
        add_vec(5'b00100, 32'hFFFF_FFF0, 32'h24, 32'hFFFF_FF00, 1, "SLL");
        add_vec(5'b00101, 32'hFFFF_FFF0, 32'h24, 32'h0FFF_FFFF, 1, "SRL");
        add_vec(5'b00110, 32'hFFFF_FFF0, 32'h24, 32'hFFFF_FFCC, 1, "SUB");
        add_vec(5'b00111, 32'hFFFF_FFF0, 32'h24, 32'h0000_0001, 1, "SLT");
        add_vec(5'b01000, 32'hFFFF_FFF0, 32'h24, 32'hFFFF_FFFF, 1, "SRA");
        add_vec(5'b01001, 32'hFFFF_FFF0, 32'h24, 32'h0000_0000, 1, "SLTU");
        add_vec(5'b00010, 32'hFFFF_FFFF, 32'h1,  32'h0000_0000, 1, "ADDwrap");
        add_vec(5'b01010, 32'h1234_5678, 32'h9,  32'h0000_0000, 1, "ILL01010");
        add_vec(5'b01111, 32'h1234_5678, 32'h9,  32'h0000_0000, 1, "ILL01111");
        add_vec(5'b11000, 32'h1234_5678, 32'h9,  32'h0000_0000, 1, "ILL11000");
        add_vec(5'b11111, 32'h1234_5678, 32'h9,  32'h0000_0000, 1, "ILL11111");
        add_vec(5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "MULH");
        add_vec(5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "MULHSU");
        add_vec(5'b10000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL");
        add_vec(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU");
        add_vec(5'b10100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33, "DIV");
        add_vec(5'b10110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33, "REM");
        add_vec(5'b10101, 32'd100, 32'd7, 32'd14, 33, "DIVU");
        add_vec(5'b10111, 32'd100, 32'd7, 32'd2,  33, "REMU");
        add_vec(5'b10100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "DIVnegb");
        add_vec(5'b10110, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 33, "REMnegb");
        add_vec(5'b10100, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1, "DIVby0");
        add_vec(5'b10110, 32'h1234_5678, 32'h0, 32'h1234_5678, 1, "REMby0");
        add_vec(5'b10101, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1, "DIVUby0");
        add_vec(5'b10111, 32'h1234_5678, 32'h0, 32'h1234_5678, 1, "REMUby0");
        add_vec(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIVovf");
        add_vec(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "REMovf");
        add_vec(5'b10101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, "DIVUbig");

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset res", 64'(res), 64'(0));
        check("reset zero", 64'(zero), 64'(1));
        check("reset busy", 64'(busy), 64'(0));
        check("reset in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].name);
        end

        // Back-to-back base ops: a new result every cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op = 5'b00010; a = 32'(i * 17); b = 32'(i + 100); in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("burst out_valid", 64'(out_valid), 64'(1));
            check("burst res", 64'(res), 64'(model(5'b00010, 32'(i * 17), 32'(i + 100))));
            $display("txn burst%0d     res=0x%08h", i, res);
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Result stall: result and in_ready frozen while out_ready is low
        @(negedge clk);
        out_ready = 1'b0;
        op = 5'b00010; a = 32'd5; b = 32'd6; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("stall first valid", 64'(out_valid), 64'(1));
        check("stall first res", 64'(res), 64'(11));
        @(negedge clk);
        op = 5'b00011; a = 32'hF0; b = 32'h0F; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("stall res stable", 64'(res), 64'(11));
            check("stall out_valid", 64'(out_valid), 64'(1));
            check("stall in_ready", 64'(in_ready), 64'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("release in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("release out_valid", 64'(out_valid), 64'(1));
        check("release res", 64'(res), 64'(32'hFF));
        $display("txn stall       res=0x%08h", res);
        @(posedge clk);
        #1;
        check("release consumed", 64'(out_valid), 64'(0));

        // Kill at iteration 10 of a DIVU, with an op presented alongside kill
        @(negedge clk);
        op = 5'b10101; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("kill busy before", 64'(busy), 64'(1));
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        op = 5'b00010; a = 32'd1; b = 32'd1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        in_valid = 1'b0;
        check("kill busy", 64'(busy), 64'(0));
        check("kill out_valid", 64'(out_valid), 64'(0));
        check("kill in_ready", 64'(in_ready), 64'(1));
        ov_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) ov_seen++;
        end
        check("kill no late result", 64'(ov_seen), 64'(0));
        $display("txn kill        busy=%0d out_valid=%0d", busy, out_valid);
        run_op(5'b00010, 32'd3, 32'd4, 32'd7, 1, "ADDpostkill");

        // Asynchronous reset mid-MUL
        @(negedge clk);
        op = 5'b10000; a = 32'd7; b = 32'hFFFF_FFFD; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("areset busy", 64'(busy), 64'(0));
        check("areset out_valid", 64'(out_valid), 64'(0));
        check("areset res", 64'(res), 64'(0));
        check("areset zero", 64'(zero), 64'(1));
        check("areset in_ready", 64'(in_ready), 64'(1));
        $display("txn areset      busy=%0d res=0x%08h", busy, res);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(5'b10000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MULpostrst");

        // Random ops against the reference model
        for (int i = 0; i < 60; i++) begin
            r_op = 5'($urandom_range(0, 31));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'h0;
                1: r_b = 32'hFFFF_FFFF;
                2: r_b = 32'($urandom_range(1, 40));
                default: ;
            endcase
            if ($urandom_range(0, 5) == 0) r_a = 32'h8000_0000;
            r_exp = model(r_op, r_a, r_b);
            run_op(r_op, r_a, r_b, r_exp, model_lat(r_op, r_a, r_b), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised, multi-cycle successor to the datapath ALU. Executes the ten base integer operations plus the RV32M/RV64M multiply/divide group behind a valid/ready handshake. Base ops complete in one cycle; multiply and divide iterate one bit per cycle on a shared shift datapath. It sits in the EX stage of the multi-cycle/pipelined core, with the EX stall driven from `in_ready`/`out_valid`.

## Interface
- `XLEN`, 32: operand/result width; 32 or 64.
- `SHW`, $clog2(XLEN): shift-amount width, taken from `b[SHW-1:0]`.
---
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands/op presented.
- `in_ready`  out  1  block can accept; transfer when `in_valid & in_ready`.
- `op`  in  5  operation code (see Operation).
- `a`, `b`  in  XLEN  operands.
- `kill`  in  1  abort the in-flight op (branch flush).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `res`  out  XLEN  registered result.
- `zero`  out  1  `res == 0`, combinational from `res`.
- `busy`  out  1  iterative op in progress.

## Operation
- Op codes `op[4]=0` (base): 00000 AND, 00001 OR, 00010 ADD, 00011 XOR, 00100 SLL, 00101 SRL, 00110 SUB, 00111 SLT (signed), 01000 SRA (sign-filling), 01001 SLTU; 01010–01111 give result 0.
- Op codes `op[4]=1` (M): 10000 MUL (low XLEN), 10001 MULH (s×s), 10010 MULHSU (s×u), 10011 MULHU (u×u), 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU; 11000–11111 give 0 with base latency.
- ADD/SUB wrap modulo 2^XLEN; SLT/SLTU produce 0 or 1.
- Shifts use only `b[SHW-1:0]`.
- FSM states:
  - IDLE: accept. Base ops, illegal ops, and divide special cases write `res` and go to IDLE with `out_valid=1`. MUL*/regular DIV* go to MUL or DIV.
  - MUL: radix-2 shift-add on operand magnitudes, XLEN iterations, 2·XLEN-bit accumulator. Sign fix-up and high/low select happen on the final iteration.
  - DIV: restoring division on magnitudes, XLEN iterations. The quotient sign is `a[XLEN-1]^b[XLEN-1]` (signed ops); the remainder takes the sign of the dividend.
- Divide special cases are resolved in IDLE and do not iterate:
  - b==0: quotient = all ones, remainder = a.
  - Signed overflow (a = −2^(XLEN−1), b = −1): quotient = a, remainder = 0.
- `in_ready = (state==IDLE) & (!out_valid | out_ready)`.
- `busy = (state!=IDLE)`.
- `out_valid` holds and `res` is stable until `out_ready`.
- `kill` has priority over everything:
  - Next state is IDLE.
  - `out_valid` is cleared.
  - Any op presented in the same cycle is not accepted.
- Reset mid-iteration behaves as `kill` (asynchronous).

## Timing
- Reset values: state IDLE, `out_valid=0`, `res=0` (so `zero=1`), `busy=0`, `in_ready=1`, iteration counter 0.
- Base/illegal/special-case divide: `out_valid` rises on the edge that accepts the op (latency 1).
- MUL*/DIV*: `out_valid` rises XLEN+1 edges after the accepting edge. `busy=1` for exactly XLEN cycles.
- Back-to-back: a result consumed (`out_ready=1`) in the same cycle a new op is accepted gives sustained one-op-per-cycle throughput for base ops.
- An iterative op followed by a base op has no bubble beyond result consumption.
- `out_ready=0` stalls acceptance. Nothing is buffered beyond one result.

## Structure
- Shared package `alu_pkg`: op-code localparams (5-bit), the FSM state enum, and the `XLEN` default.
- One natural sub-module, `seq_muldiv`: the iterative multiply/divide engine (magnitude conversion, counter, shift registers, sign fix-up) with `start`/`done` to the top.
- The top holds the combinational base-op mux, the special-case decode, the FSM and the handshake.

## Test plan
- Base ops: a=0xFFFF_FFF0, b=0x0000_0024 for all ten codes. Expected: SRA → 0xFFFF_FFFF; SLL → 0xFFFF_FF00 (shamt 4); SLT → 1; SLTU → 0; `zero` tracks `res`. Latency 1.
- MULH a=0x8000_0000, b=0x8000_0000 → 0x4000_0000. MULHSU a=−1, b=0xFFFF_FFFF → 0xFFFF_FFFF. MUL 7×−3 → 0xFFFF_FFEB. Each arrives exactly 33 edges after accept, with `busy` high for 32 cycles.
- Divides:
  - DIV −7/2 → 0xFFFF_FFFD; REM −7/2 → 0xFFFF_FFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
  - DIV x/0 → 0xFFFF_FFFF; REM x/0 → x, at latency 1.
  - DIV 0x8000_0000/−1 → 0x8000_0000, with REM → 0.
- Handshake: hold `out_ready=0` for 5 cycles after a result. Required: `res` stable, `in_ready=0`. Then release `out_ready` with `in_valid` high: accept and consume occur in the same cycle.
- Kill: assert `kill` at iteration 10 of a DIVU. Required: next cycle IDLE, `out_valid=0`, `busy=0`. A following ADD 3+4 → 7 at latency 1.
- Reset: drop `rst_n` asynchronously mid-MUL. Required: all outputs reach reset values before the next edge; normal operation resumes after release.
